// File: rtl/multiport_regfile_pkg.sv
// Shared types and default sizes for the multiport register file.
package multiport_regfile_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 5;

endpackage

// File: rtl/regfile_rd_mux.sv
// One read port: zero-register masking, busy blanking and write-through bypass.
module regfile_rd_mux
    import multiport_regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic              busy,
    input  logic [ADDR_W-1:0] ra,
    input  logic              we0,
    input  logic [ADDR_W-1:0] wa0,
    input  logic [DATA_W-1:0] wd0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] wa1,
    input  logic [DATA_W-1:0] wd1,
    input  logic [DATA_W-1:0] stored,
    output logic [DATA_W-1:0] rd_c
);

    localparam bit ZERO_EN = (ZERO_REG != 0);

    // Port 1 bypass beats port 0 bypass beats the stored value
    always_comb begin
        rd_c = stored;
        if (busy || (ZERO_EN && (ra == '0))) begin
            rd_c = '0;
        end else if (we1 && (wa1 == ra)) begin
            rd_c = wd1;
        end else if (we0 && (wa0 == ra)) begin
            rd_c = wd0;
        end
    end

endmodule

// File: rtl/multiport_regfile.sv
// Two-write, NRD-read register file with a power-up clear sequence and a
// registered debug read port.
module multiport_regfile
    import multiport_regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned NRD      = 2,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  busy,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [ADDR_W-1:0]     wa0,
    input  logic [ADDR_W-1:0]     wa1,
    input  logic [DATA_W-1:0]     wd0,
    input  logic [DATA_W-1:0]     wd1,
    input  logic [NRD*ADDR_W-1:0] ra,
    output logic [NRD*DATA_W-1:0] rd,
    input  logic [ADDR_W-1:0]     dbg_addr,
    output logic [DATA_W-1:0]     dbg_data
);

    localparam int unsigned DEPTH   = 2 ** ADDR_W;
    localparam bit          ZERO_EN = (ZERO_REG != 0);

    state_e            state;
    state_e            state_next;
    logic [ADDR_W-1:0] clr_cnt;
    logic [ADDR_W-1:0] clr_cnt_next;
    logic              wr0_en;
    logic              wr1_en;
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_next;
            clr_cnt <= clr_cnt_next;
        end
    end

    // Walk the clear counter over every address, then hand over to RUN
    always_comb begin
        state_next   = state;
        clr_cnt_next = clr_cnt;
        case (state)
            CLEAR: begin
                clr_cnt_next = clr_cnt + ADDR_W'(1);
                if (clr_cnt == ADDR_W'(DEPTH - 1)) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                state_next = RUN;
            end
            default: begin
                state_next = CLEAR;
            end
        endcase
    end

    assign busy   = (state == CLEAR);
    assign wr0_en = we0 && !busy && !(ZERO_EN && (wa0 == '0));
    assign wr1_en = we1 && !busy && !(ZERO_EN && (wa1 == '0));

    // Port 1 is written last so it wins an address collision
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (busy) begin
                mem[clr_cnt] <= '0;
            end else begin
                if (wr0_en) mem[wa0] <= wd0;
                if (wr1_en) mem[wa1] <= wd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dbg_data <= '0;
        end else begin
            dbg_data <= mem[dbg_addr];
        end
    end

    for (genvar k = 0; k < int'(NRD); k++) begin : g_rd
        logic [ADDR_W-1:0] ra_k;
        assign ra_k = ra[k*ADDR_W +: ADDR_W];

        regfile_rd_mux #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG)
        ) u_rd_mux (
            .busy   (busy),
            .ra     (ra_k),
            .we0    (we0),
            .wa0    (wa0),
            .wd0    (wd0),
            .we1    (we1),
            .wa1    (wa1),
            .wd1    (wd1),
            .stored (mem[ra_k]),
            .rd_c   (rd[k*DATA_W +: DATA_W])
        );
    end

endmodule

// File: doc/multiport_regfile.md
MULTIPORT_REGFILE -- requirements
Module: multiport_regfile

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, address width; DEPTH = 2**ADDR_W registers.
REQ-003 SHALL have parameter NRD, default 2, number of read ports.
REQ-004 SHALL have parameter ZERO_REG, default 1: 1 = register 0 hardwired to zero; 0 = register 0 is ordinary.
REQ-005 SHALL have port clk, input, 1, sole clock; all state updates on the rising edge.
REQ-006 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-007 SHALL have port busy, output, 1, high while the clear sequence runs.
REQ-008 SHALL have ports we0/we1, input, 1 each, write enables for write ports 0 and 1.
REQ-009 SHALL have ports wa0/wa1, input, ADDR_W each, write addresses.
REQ-010 SHALL have ports wd0/wd1, input, DATA_W each, write data.
REQ-011 SHALL have port ra, input, NRD*ADDR_W, packed read addresses; port k occupies slice k.
REQ-012 SHALL have port rd, output, NRD*DATA_W, packed read data; port k occupies slice k.
REQ-013 SHALL have port dbg_addr, input, ADDR_W, debug read address, driven from board switches.
REQ-014 SHALL have port dbg_data, output, DATA_W, registered debug read data.

Function
REQ-015 SHALL implement a two-state FSM, CLEAR and RUN; reset forces CLEAR with the clear counter at 0.
REQ-016 In CLEAR, SHALL write 0 to register[counter] each cycle and increment the counter; after the write to DEPTH-1, SHALL enter RUN on the next edge (DEPTH cycles total).
REQ-017 busy SHALL equal (state == CLEAR).
REQ-018 While busy, SHALL ignore we0/we1 and drive every rd slice to 0.
REQ-019 In RUN, SHALL apply writes on the clock edge; if we0 and we1 are both set and wa0 == wa1, write port 1 SHALL win.
REQ-020 When ZERO_REG = 1, writes to address 0 SHALL be discarded and reads of address 0 SHALL return 0.
REQ-021 Reads SHALL be combinational (0-cycle latency) with write-through bypass.
REQ-022 Bypass: if a read address matches an enabled write address in the same cycle, rd SHALL return that write data.
REQ-023 Bypass priority SHALL be port 1 over port 0 over stored value.
REQ-024 Bypass SHALL be suppressed for address 0 when ZERO_REG = 1, and suppressed entirely while busy.
REQ-025 dbg_data SHALL register the stored value at dbg_addr each cycle (1-cycle latency).
REQ-026 dbg_data SHALL have no bypass and SHALL update while busy, showing cleared or old contents.
REQ-027 Reset asserted mid-CLEAR or mid-RUN SHALL restart the clear sequence from counter 0; a write presented in the reset cycle SHALL be discarded.

Reset
REQ-028 On reset SHALL set state = CLEAR, counter = 0, dbg_data = 0; busy reads 1 in the cycle after reset.
REQ-029 Register contents SHALL be undefined until the clear sequence completes, but SHALL never be observable on rd during that time (REQ-018).

Structure
REQ-030 Shared package SHALL hold the FSM state enum (CLEAR, RUN) and default constants DATA_W_DEF = 32, ADDR_W_DEF = 5.
REQ-031 Bypass/priority selection per read port SHALL be one sub-module, regfile_rd_mux, instantiated NRD times via generate.

Verification
REQ-032 Reset, then hold idle: busy = 1 for exactly 32 cycles, then 0; every register reads 0 on rd and dbg_data.
REQ-033 RUN, we0 = 1, wa0 = 5, wd0 = 0xDEADBEEF, ra slice0 = 5 in the same cycle: rd0 = 0xDEADBEEF that cycle; stored value remains next cycle.
REQ-034 Dual write, wa0 = wa1 = 7, wd0 = 0x11, wd1 = 0x22: reg 7 = 0x22; same-cycle read of 7 returns 0x22.
REQ-035 Write 0xFFFFFFFF to address 0 with ZERO_REG = 1: rd and dbg_data for address 0 remain 0; with ZERO_REG = 0, both read 0xFFFFFFFF.
REQ-036 Reset at clear counter 10, then a write attempt during busy: busy is held for a full 32 further cycles and the write does not land.
REQ-037 dbg_addr = 3 after writing 0xA5 to reg 3: dbg_data = 0xA5 exactly one cycle after dbg_addr is applied.
